// File: rtl/fpc_dispatch.sv
// rtl/fpc_dispatch.sv - command FIFO, issue sequencer and tagged result return for Fpc (optional FPC_DISP_TIMEOUT_EN watchdog)
module fpc_dispatch #(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_mode,
    input  logic [15:0]                cmd_a,
    input  logic [15:0]                cmd_b,
    output logic                       fpc_in_valid,
    output logic [15:0]                fpc_in_a,
    output logic [15:0]                fpc_in_b,
    output logic                       fpc_mode,
    input  logic                       fpc_out_valid,
    input  logic [15:0]                fpc_out,
    output logic                       res_valid,
    output logic [15:0]                res_data,
    output logic [TAG_W-1:0]           res_tag,
    output logic                       res_err,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ENT_W = 1 + 16 + 16 + TAG_W;

    // Pointer arithmetic relies on natural wrap, so DEPTH must be a power of two.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_params
        $error("fpc_dispatch: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESULT
    } state_t;

    logic [ENT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [TAG_W-1:0] tag_q;
    logic [TAG_W-1:0] cur_tag;
    logic [ENT_W-1:0] head;
    logic             push;
    logic             pop;
    state_t           state;

`ifdef FPC_DISP_TIMEOUT_EN
    localparam int WCNT_W = $clog2(TIMEOUT + 1);
    logic [WCNT_W-1:0] wait_cnt;
    logic              res_err_q;
    assign res_err = res_err_q;
`else
    assign res_err = 1'b0;
`endif

    // No bypass: a full FIFO refuses even when the FSM pops this cycle.
    assign cmd_ready  = (count < CNT_W'(DEPTH));
    assign push       = cmd_valid & cmd_ready;
    assign pop        = (state == S_IDLE) && (count != '0);
    assign head       = mem[rd_ptr];
    assign fifo_count = count;

    // Command storage: mode, operands and the tag assigned at accept time.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_mode, cmd_a, cmd_b, tag_q};
        end
    end

    // FIFO pointers, occupancy and the sequence tag counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            tag_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                tag_q  <= tag_q + TAG_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Issue/wait/result sequencer; all Fpc and result outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            fpc_in_valid <= 1'b0;
            fpc_in_a     <= '0;
            fpc_in_b     <= '0;
            fpc_mode     <= 1'b0;
            cur_tag      <= '0;
            res_valid    <= 1'b0;
            res_data     <= '0;
            res_tag      <= '0;
`ifdef FPC_DISP_TIMEOUT_EN
            wait_cnt     <= '0;
            res_err_q    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    res_valid <= 1'b0;
                    if (pop) begin
                        fpc_mode     <= head[ENT_W-1];
                        fpc_in_a     <= head[ENT_W-2 -: 16];
                        fpc_in_b     <= head[TAG_W+15 -: 16];
                        cur_tag      <= head[TAG_W-1:0];
                        fpc_in_valid <= 1'b1;
                        state        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    fpc_in_valid <= 1'b0;
`ifdef FPC_DISP_TIMEOUT_EN
                    wait_cnt     <= '0;
`endif
                    state        <= S_WAIT;
                end
                S_WAIT: begin
                    // A real result wins over the watchdog when both land together.
                    if (fpc_out_valid) begin
                        res_data  <= fpc_out;
                        res_tag   <= cur_tag;
                        res_valid <= 1'b1;
`ifdef FPC_DISP_TIMEOUT_EN
                        res_err_q <= 1'b0;
`endif
                        state     <= S_RESULT;
                    end
`ifdef FPC_DISP_TIMEOUT_EN
                    else if (wait_cnt == WCNT_W'(TIMEOUT - 1)) begin
                        res_data  <= 16'h7FC0;
                        res_tag   <= cur_tag;
                        res_valid <= 1'b1;
                        res_err_q <= 1'b1;
                        state     <= S_RESULT;
                    end else begin
                        wait_cnt  <= wait_cnt + WCNT_W'(1);
                    end
`endif
                end
                S_RESULT: begin
                    res_valid <= 1'b0;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
